sync_fifo_flex: RTL and testbench
=================================

// Module: sync_fifo_flex
// PURPOSE
//  Parametrised single-clock FIFO; next generation of the team's basic sync FIFO.
//  Adds programmable almost-full/almost-empty thresholds, a first-word-fall-through mode,
//  a synchronous flush, a read-valid strobe and any-integer DEPTH.
//  Sits between streaming producers/consumers in one clock domain.
// PARAMETERS
//  WIDTH      32             data word width, >=1
//  DEPTH      16             number of entries, any integer >=2 (not restricted to powers of 2)
//  AF_THRESH  DEPTH-2        almost_full asserted when count >= AF_THRESH (1..DEPTH)
//  AE_THRESH  2              almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
//  MODE       FIFO_STD       FIFO_STD: registered read; FIFO_FWFT: head word shown on rd_data
//  CW         $clog2(DEPTH+1) count width (localparam)
// PORTS
//  clk           in   1      clock
//  rst_n         in   1      asynchronous active-low reset
//  clr           in   1      synchronous flush, active high
//  wr_en         in   1      write request
//  wr_data       in   WIDTH  write data
//  full          out  1      count == DEPTH
//  almost_full   out  1      count >= AF_THRESH
//  rd_en         in   1      read request (STD) / pop (FWFT)
//  rd_data       out  WIDTH  read data
//  rd_valid      out  1      rd_data qualifier
//  empty         out  1      count == 0
//  almost_empty  out  1      count <= AE_THRESH
//  count         out  CW     current occupancy, 0..DEPTH
//  overflow      out  1      sticky: write attempted while full
//  underflow     out  1      sticky: read attempted while empty
// BEHAVIOUR
//  - Reset (async): pointers=0, count=0, rd_data=0, rd_valid=0, overflow=underflow=0;
//    hence empty=1, almost_empty=1, full=0, almost_full=0.
//  - Write accepted iff wr_en && !full. Read accepted iff rd_en && !empty. A request that is
//    not accepted is dropped; FIFO state is unchanged.
//  - Simultaneous accepted write+read: count unchanged, both pointers advance.
//    When full, only the read is accepted. When empty, only the write is accepted;
//    no pass-through in either mode.
//  - Pointers wrap from DEPTH-1 to 0. count is a separate register, +1/-1/0 per cycle.
//  - Flags are combinational decodes of registered count; no X on flags after reset.
//  - FIFO_STD: rd_data is registered from mem[rd_ptr] on an accepted read.
//    rd_valid is high for exactly one cycle after each accepted read (1-cycle latency).
//    rd_data holds its last value otherwise.
//  - FIFO_FWFT: rd_data = mem[rd_ptr] (combinational read); rd_valid = !empty.
//    rd_en acknowledges and pops the head. A word written to an empty FIFO appears on
//    rd_data the cycle after the write edge.
//  - clr: at the next edge, pointers=0, count=0, rd_valid=0 and sticky flags are cleared.
//    clr overrides wr_en and rd_en in the same cycle. Memory contents are not cleared.
//  - Async reset mid-operation discards all contents immediately; storage needs no reset.
// CONFIGURATION
//  Macro SYNC_FIFO_ERR_FLAGS_EN.
//  - Defined: overflow sets on (wr_en && full && !clr); underflow sets on
//    (rd_en && empty && !clr). Both are sticky until rst_n or clr.
//  - Undefined: overflow and underflow are tied to 0 and no flag registers are synthesised.
//    Ports remain present in both cases.
// STRUCTURE
//  - sync_fifo_pkg: typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;
//    function fifo_cw(depth) returning the count width.
//  - Sub-module sync_fifo_mem: 1-write/1-async-read storage array, WIDTH x DEPTH, no reset.
//  - Top level holds the pointers, count, flag decode, read register and error flags.
// TESTING
//  - Reset: hold rst_n=0 for 5 cycles -> empty=1, almost_empty=1, full=0, count=0, rd_valid=0.
//  - Fill/drain, STD mode, DEPTH=16: write 0xCAFE0000..+15 -> full=1, count=16,
//    almost_full from count 14. Then 16 reads -> data in order, each with a one-cycle
//    rd_valid; empty=1 at the end.
//  - Non-power-of-2 DEPTH=5, 3 full fill/drain passes -> wrap is correct and no data is lost.
//  - Full/empty contention: when full, wr_en=rd_en=1 -> only the read is accepted, count=15.
//    When empty, both high -> count=1 and rd_valid stays 0.
//  - FWFT: write 0xA5 to an empty FIFO -> next cycle rd_data=0xA5, rd_valid=1.
//    rd_en pops it -> empty=1.
//  - clr with wr_en=1 at count=7 -> count=0, empty=1. With SYNC_FIFO_ERR_FLAGS_EN: a write
//    when full sets overflow, which stays set until clr; a read when empty sets underflow.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared types and helpers for the sync_fifo_flex family.
package sync_fifo_pkg;
  typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;
  function automatic int fifo_cw(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: 1-write / 1-async-read storage array, no reset.
module sync_fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (wr_en) r_mem[wr_addr] <= wr_data;
  assign rd_data = r_mem[rd_addr];
endmodule

// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FIFO, any DEPTH, STD/FWFT read, flush, thresholds.
// Define SYNC_FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow registers.
module sync_fifo_flex import sync_fifo_pkg::*; #(
  parameter int         WIDTH     = 32,
  parameter int         DEPTH     = 16,
  parameter int         AF_THRESH = DEPTH - 2,
  parameter int         AE_THRESH = 2,
  parameter fifo_mode_e MODE      = FIFO_STD,
  localparam int        CW        = fifo_cw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             almost_full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             empty,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] w_mem_rdata;
  logic             w_wr_acc, w_rd_acc;
  assign w_wr_acc     = wr_en && !full;
  assign w_rd_acc     = rd_en && !empty;
  assign count        = r_count;
  assign full         = r_count == CW'(DEPTH);
  assign empty        = r_count == '0;
  assign almost_full  = r_count >= CW'(AF_THRESH);
  assign almost_empty = r_count <= CW'(AE_THRESH);
  sync_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .wr_en   (w_wr_acc && !clr),
    .wr_addr (r_wr_ptr),
    .wr_data (wr_data),
    .rd_addr (r_rd_ptr),
    .rd_data (w_mem_rdata)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      if (w_wr_acc != w_rd_acc) r_count <= w_wr_acc ? r_count + 1'b1 : r_count - 1'b1;
    end
  generate
    if (MODE == FIFO_STD) begin : g_std
      logic [WIDTH-1:0] r_rd_data;
      logic             r_rd_valid;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          r_rd_data  <= '0;
          r_rd_valid <= 1'b0;
        end else if (clr) begin
          r_rd_valid <= 1'b0;
        end else begin
          r_rd_valid <= w_rd_acc;
          if (w_rd_acc) r_rd_data <= w_mem_rdata;
        end
      assign rd_data  = r_rd_data;
      assign rd_valid = r_rd_valid;
    end else begin : g_fwft
      assign rd_data  = w_mem_rdata;
      assign rd_valid = !empty;
    end
  endgenerate
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic r_overflow, r_underflow;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clr) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && full)  r_overflow  <= 1'b1;
      if (rd_en && empty) r_underflow <= 1'b1;
    end
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif
endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb_sync_fifo_flex: scoreboard bench for sync_fifo_flex (STD D16, STD D5, FWFT D4).
module tb_sync_fifo_flex;
  import sync_fifo_pkg::*;
  logic clk, rst_n;
  int n_chk = 0, n_fail = 0;
  logic        a_clr = 0, a_wr = 0, a_rd = 0;
  logic [31:0] a_wd = 0, a_rdata;
  logic        a_full, a_af, a_rv, a_empty, a_ae, a_ov, a_un;
  logic [4:0]  a_cnt;
  logic        b_clr = 0, b_wr = 0, b_rd = 0;
  logic [15:0] b_wd = 0, b_rdata;
  logic        b_full, b_af, b_rv, b_empty, b_ae, b_ov, b_un;
  logic [2:0]  b_cnt;
  logic        f_clr = 0, f_wr = 0, f_rd = 0;
  logic [7:0]  f_wd = 0, f_rdata;
  logic        f_full, f_af, f_rv, f_empty, f_ae, f_ov, f_un;
  logic [2:0]  f_cnt;
  logic [31:0] ma[$], ea[$], mb[$], eb[$];
  bit          ov_a = 0, un_a = 0;

  sync_fifo_flex #(.WIDTH(32), .DEPTH(16), .MODE(FIFO_STD)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(a_clr), .wr_en(a_wr), .wr_data(a_wd),
    .full(a_full), .almost_full(a_af), .rd_en(a_rd), .rd_data(a_rdata),
    .rd_valid(a_rv), .empty(a_empty), .almost_empty(a_ae), .count(a_cnt),
    .overflow(a_ov), .underflow(a_un));
  sync_fifo_flex #(.WIDTH(16), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .MODE(FIFO_STD)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(b_clr), .wr_en(b_wr), .wr_data(b_wd),
    .full(b_full), .almost_full(b_af), .rd_en(b_rd), .rd_data(b_rdata),
    .rd_valid(b_rv), .empty(b_empty), .almost_empty(b_ae), .count(b_cnt),
    .overflow(b_ov), .underflow(b_un));
  sync_fifo_flex #(.WIDTH(8), .DEPTH(4), .MODE(FIFO_FWFT)) u_f (
    .clk(clk), .rst_n(rst_n), .clr(f_clr), .wr_en(f_wr), .wr_data(f_wd),
    .full(f_full), .almost_full(f_af), .rd_en(f_rd), .rd_data(f_rdata),
    .rd_valid(f_rv), .empty(f_empty), .almost_empty(f_ae), .count(f_cnt),
    .overflow(f_ov), .underflow(f_un));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitors: every rd_valid pulse must match the oldest outstanding read.
  always @(negedge clk)
    if (rst_n && a_rv) begin
      if (ea.size() == 0) chk("a_unexpected_rd_valid", 32'd1, 32'd0);
      else chk("a_rd_data", a_rdata, ea.pop_front());
    end
  always @(negedge clk)
    if (rst_n && b_rv) begin
      if (eb.size() == 0) chk("b_unexpected_rd_valid", 32'd1, 32'd0);
      else chk("b_rd_data", {16'h0, b_rdata}, eb.pop_front());
    end

  task automatic a_op(input bit c, input bit w, input bit r, input logic [31:0] d);
    bit ra, wa;
    a_clr = c; a_wr = w; a_rd = r; a_wd = d;
    ra = r && ma.size() > 0;
    wa = w && ma.size() < 16;
    if (c) begin
      ma.delete();
      ov_a = 0; un_a = 0;
    end else begin
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      if (w && ma.size() == 16) ov_a = 1;
      if (r && ma.size() == 0) un_a = 1;
`endif
      if (ra) ea.push_back(ma.pop_front());
      if (wa) ma.push_back(d);
    end
    step();
    a_clr = 0; a_wr = 0; a_rd = 0;
    chk("a_count", {27'h0, a_cnt}, ma.size());
    chk("a_full", {31'h0, a_full}, {31'h0, ma.size() == 16});
    chk("a_almost_full", {31'h0, a_af}, {31'h0, ma.size() >= 14});
    chk("a_empty", {31'h0, a_empty}, {31'h0, ma.size() == 0});
    chk("a_almost_empty", {31'h0, a_ae}, {31'h0, ma.size() <= 2});
    chk("a_overflow", {31'h0, a_ov}, {31'h0, ov_a});
    chk("a_underflow", {31'h0, a_un}, {31'h0, un_a});
  endtask

  task automatic b_op(input bit w, input bit r, input logic [15:0] d);
    b_wr = w; b_rd = r; b_wd = d;
    if (r && mb.size() > 0) eb.push_back(mb.pop_front());
    if (w && mb.size() < 5) mb.push_back({16'h0, d});
    step();
    b_wr = 0; b_rd = 0;
    chk("b_count", {29'h0, b_cnt}, mb.size());
    chk("b_full", {31'h0, b_full}, {31'h0, mb.size() == 5});
    chk("b_empty", {31'h0, b_empty}, {31'h0, mb.size() == 0});
  endtask

  initial begin
    rst_n = 0;
    repeat (5) step();
    chk("rst_empty", {31'h0, a_empty}, 32'd1);
    chk("rst_almost_empty", {31'h0, a_ae}, 32'd1);
    chk("rst_full", {31'h0, a_full}, 32'd0);
    chk("rst_almost_full", {31'h0, a_af}, 32'd0);
    chk("rst_count", {27'h0, a_cnt}, 32'd0);
    chk("rst_rd_valid", {31'h0, a_rv}, 32'd0);
    chk("rst_rd_data", a_rdata, 32'd0);
    chk("rst_fwft_valid", {31'h0, f_rv}, 32'd0);
    rst_n = 1;
    step();
    // Fill and drain the 16-deep STD FIFO
    for (int i = 0; i < 16; i++) begin
      a_op(0, 1, 0, 32'hCAFE_0000 + i);
      if (i == 12) chk("af_below_thresh", {31'h0, a_af}, 32'd0);
      if (i == 13) chk("af_at_14", {31'h0, a_af}, 32'd1);
    end
    chk("fill_full", {31'h0, a_full}, 32'd1);
    chk("fill_count", {27'h0, a_cnt}, 32'd16);
    a_op(0, 1, 1, 32'hDEAD_BEEF);
    chk("full_contention_count", {27'h0, a_cnt}, 32'd15);
    for (int i = 0; i < 15; i++) a_op(0, 0, 1, 32'h0);
    a_op(0, 0, 0, 32'h0);
    chk("drain_empty", {31'h0, a_empty}, 32'd1);
    a_op(0, 1, 1, 32'h1234_5678);
    chk("empty_contention_count", {27'h0, a_cnt}, 32'd1);
    chk("empty_contention_valid", {31'h0, a_rv}, 32'd0);
    for (int i = 0; i < 6; i++) a_op(0, 1, 0, 32'h7000_0000 + i);
    chk("pre_clr_count", {27'h0, a_cnt}, 32'd7);
    a_op(1, 1, 0, 32'hFFFF_FFFF);
    chk("clr_count", {27'h0, a_cnt}, 32'd0);
    chk("clr_empty", {31'h0, a_empty}, 32'd1);
    a_op(0, 0, 1, 32'h0);
    a_op(0, 0, 0, 32'h0);
    for (int i = 0; i < 16; i++) a_op(0, 1, 0, 32'h4000_0000 + i);
    a_op(0, 1, 0, 32'hBAD0_BAD0);
    a_op(0, 0, 0, 32'h0);
    a_op(0, 0, 1, 32'h0);
    a_op(0, 0, 0, 32'h0);
    a_op(1, 0, 0, 32'h0);
    chk("clr_overflow", {31'h0, a_ov}, 32'd0);
    chk("clr_underflow", {31'h0, a_un}, 32'd0);
    // Non-power-of-2 depth: three full passes across the pointer wrap
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 5; i++) b_op(1, 0, 16'h5000 + 16'(p * 16 + i));
      b_op(1, 0, 16'hEEEE);
      chk("b_pass_full", {31'h0, b_full}, 32'd1);
      for (int i = 0; i < 5; i++) b_op(0, 1, 16'h0);
      b_op(0, 0, 16'h0);
      chk("b_pass_empty", {31'h0, b_empty}, 32'd1);
    end
    b_op(1, 0, 16'h0A0A);
    b_op(1, 1, 16'h0B0B);
    b_op(0, 1, 16'h0);
    b_op(0, 1, 16'h0);
    b_op(0, 0, 16'h0);
    // FWFT: head word visible the cycle after the write edge
    f_wr = 1; f_wd = 8'hA5;
    step();
    f_wr = 0;
    chk("fwft_head", {24'h0, f_rdata}, 32'hA5);
    chk("fwft_valid", {31'h0, f_rv}, 32'd1);
    f_rd = 1;
    step();
    f_rd = 0;
    chk("fwft_pop_empty", {31'h0, f_empty}, 32'd1);
    chk("fwft_pop_valid", {31'h0, f_rv}, 32'd0);
    f_wr = 1; f_wd = 8'h11; step();
    f_wd = 8'h22; step();
    f_wd = 8'h33; f_rd = 1; step();
    f_wr = 0; f_rd = 0;
    chk("fwft_head2", {24'h0, f_rdata}, 32'h22);
    chk("fwft_count2", {29'h0, f_cnt}, 32'd2);
    f_rd = 1; step();
    chk("fwft_head3", {24'h0, f_rdata}, 32'h33);
    step();
    f_rd = 0;
    chk("fwft_final_empty", {31'h0, f_empty}, 32'd1);
    step();
    step();
    chk("a_outstanding_reads", ea.size(), 32'd0);
    chk("b_outstanding_reads", eb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
